multi_bank_buffer: RTL and testbench
====================================

# multi_bank_buffer

N-bank generalisation of the accelerator's ping-pong double buffer. A producer fills banks in round-robin order and commits each one; a consumer reads committed banks in the same order and releases them. This lets ifmap/weight staging run several tiles ahead instead of one. Bank ownership is tracked by explicit commit/release handshakes with occupancy flow control, replacing the blind `switch_banks` toggle.

## Interface
- `DATA_WIDTH`, 64, word width.
- `BANK_ADDR_WIDTH`, 9, address width within a bank.
- `BANK_DEPTH`, 200, words per bank; legal addresses are 0..BANK_DEPTH-1.
- `NUM_BANKS`, 4, number of banks; must be ≥2. Bank index width is $clog2(NUM_BANKS). Occupancy width is $clog2(NUM_BANKS+1).
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `wen` input 1: write strobe into the current write bank.
- `wadr` input BANK_ADDR_WIDTH: write address.
- `wdata` input DATA_WIDTH: write data.
- `wr_commit` input 1: hand the current write bank to the consumer.
- `wr_ready` output 1: a free write bank exists (occupancy < NUM_BANKS).
- `ren` input 1: read strobe from the current read bank.
- `radr` input BANK_ADDR_WIDTH: read address.
- `rdata` output DATA_WIDTH: registered read data.
- `rvalid` output 1: `rdata` was updated by the read accepted in the previous cycle.
- `rd_release` input 1: return the current read bank to the producer.
- `rd_ready` output 1: a committed bank is available (occupancy > 0).
- `wr_bank` output bank index width: current write bank index.
- `rd_bank` output bank index width: current read bank index.
- `occupancy` output occupancy width: committed, unreleased banks (0..NUM_BANKS).
- `err` output 1: sticky protocol-violation flag.

## Operation
- **State:** `wr_ptr`, `rd_ptr`, `occupancy`, `rdata`, `rvalid`, `err`, plus NUM_BANKS×BANK_DEPTH storage.
- **Combinational outputs:** `wr_ready` = occupancy≠NUM_BANKS; `rd_ready` = occupancy≠0; `wr_bank` = `wr_ptr`; `rd_bank` = `rd_ptr`.
- **Write:** accepted when `wen` & `wr_ready` & `wadr` < BANK_DEPTH. It stores `wdata` at bank[`wr_ptr`][`wadr`].
- **Read:** accepted when `ren` & `rd_ready` & `radr` < BANK_DEPTH. It loads bank[`rd_ptr`][`radr`] into `rdata`.
- **Commit:** accepted when `wr_commit` & `wr_ready`. `wr_ptr` advances, wrapping NUM_BANKS-1→0, and occupancy increments.
- **Release:** accepted when `rd_release` & `rd_ready`. `rd_ptr` advances with the same wrap, and occupancy decrements.
- **Simultaneous commit and release** (both accepted): both pointers advance and occupancy is unchanged.
- **Acceptance is judged on the registered occupancy at the start of the cycle.**
  - A commit while full is rejected even if a release arrives in the same cycle.
  - A release while empty is rejected even if a commit arrives in the same cycle.
- **Same-cycle data and pointer moves:** `wen` in the same cycle as an accepted commit writes the old bank. `ren` in the same cycle as an accepted release reads the old bank.
- **No collision:** the read and write banks coincide only when occupancy is 0 (reads blocked) or NUM_BANKS (writes blocked). No read/write collision handling is needed.
- **Rejected strobes** (`wen`, `ren`, `wr_commit`, `rd_release` while not ready, or out-of-range `wadr`/`radr`): no state change except `err` is set to 1. `err` clears only on reset.
- **Memory contents** are not reset. A read of a never-written location returns an undefined value that a bench must not check.

## Timing
- **Reset values:** `wr_ptr`=0, `rd_ptr`=0, `occupancy`=0, `wr_ready`=1, `rd_ready`=0, `wr_bank`=0, `rd_bank`=0, `rdata`=0, `rvalid`=0, `err`=0.
- **Reset mid-operation** discards all committed banks immediately (asynchronous).
- **Read latency is 1 cycle.** `rvalid` is high for exactly the cycle after an accepted read. Otherwise `rvalid` is 0 and `rdata` holds its last value.
- **Write-to-commit:** a write at edge N followed by a commit at edge N or later is readable from the first cycle after the commit edge.
- **Flag timing:** `occupancy`, `wr_ready` and `rd_ready` reflect a commit or release from the cycle after its edge.
- **Throughput:** one write and one read per cycle, concurrently.

## Test plan
- **Reset:** assert `rst_n`=0 with random inputs → all outputs at their reset values; `wr_ready`=1, `rd_ready`=0.
- **Single bank:** wen `wadr`=199 `wdata`=64'hDEADBEEFDEADBEEF, then commit → next cycle `occupancy`=1, `rd_ready`=1, `wr_bank`=1. Then ren `radr`=199 → next cycle `rvalid`=1 and `rdata`=64'hDEADBEEFDEADBEEF.
- **Fill:** write address 0 of banks 0..3 with values 1..4, committing each → after the 4th commit `occupancy`=4, `wr_ready`=0, `wr_bank`=0. A 5th wen with data 5 plus commit → ignored and `err`=1. Read-then-release four times → `rdata` sequence 1,2,3,4, ending with `occupancy`=0.
- **Concurrent commit/release:** at occupancy 2 with `wr_bank`=3, pulse commit and release together → `occupancy` stays 2, `wr_bank`=0 (wrap), `rd_bank` increments.
- **Empty violations:** with occupancy 0, pulse `rd_release` and `ren` → `rvalid` stays 0, `rd_bank` is unchanged and `err`=1. Also wen with `wadr`=200 → no write and `err`=1.
- **Reset mid-operation:** reach occupancy 3, then pulse `rst_n` low mid-cycle → outputs reset asynchronously and `rd_ready`=0.

Source files
------------

// File: rtl/multi_bank_buffer.sv
// multi_bank_buffer: N-bank round-robin staging buffer. A producer fills
// and commits banks in order and a consumer reads and releases them in the
// same order. Bank ownership follows the commit/release handshakes, and the
// occupancy count provides flow control in both directions.
module multi_bank_buffer #(
  parameter int DATA_WIDTH      = 64,
  parameter int BANK_ADDR_WIDTH = 9,
  parameter int BANK_DEPTH      = 200,
  parameter int NUM_BANKS       = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wen,
  input  logic [BANK_ADDR_WIDTH-1:0]       wadr,
  input  logic [DATA_WIDTH-1:0]            wdata,
  input  logic                             wr_commit,
  output logic                             wr_ready,
  input  logic                             ren,
  input  logic [BANK_ADDR_WIDTH-1:0]       radr,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic                             rvalid,
  input  logic                             rd_release,
  output logic                             rd_ready,
  output logic [$clog2(NUM_BANKS)-1:0]     wr_bank,
  output logic [$clog2(NUM_BANKS)-1:0]     rd_bank,
  output logic [$clog2(NUM_BANKS+1)-1:0]   occupancy,
  output logic                             err
);

  localparam int IDX_W  = $clog2(NUM_BANKS);
  localparam int OCC_W  = $clog2(NUM_BANKS + 1);
  localparam int MEM_AW = $clog2(NUM_BANKS * BANK_DEPTH);

  localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(NUM_BANKS - 1);
  localparam logic [OCC_W-1:0]         FULL_OCC = OCC_W'(NUM_BANKS);
  localparam logic [BANK_ADDR_WIDTH:0] ADR_LIM  = (BANK_ADDR_WIDTH + 1)'(BANK_DEPTH);

  // All banks live in one flat array; bank b occupies [b*BANK_DEPTH +: BANK_DEPTH].
  logic [DATA_WIDTH-1:0] mem [NUM_BANKS*BANK_DEPTH];

  logic [IDX_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [IDX_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  err_q, err_d;

  logic                  w_in_range, r_in_range;
  logic                  w_ok, r_ok, c_ok, rl_ok;
  logic [MEM_AW-1:0]     waddr_flat, raddr_flat;

  assign wr_ready  = (occ_q != FULL_OCC);
  assign rd_ready  = (occ_q != '0);
  assign wr_bank   = wr_ptr_q;
  assign rd_bank   = rd_ptr_q;
  assign occupancy = occ_q;
  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign err       = err_q;

  // Acceptance of each strobe, judged on the occupancy held at cycle start.
  always_comb begin
    w_in_range = ({1'b0, wadr} < ADR_LIM);
    r_in_range = ({1'b0, radr} < ADR_LIM);
    w_ok       = wen & wr_ready & w_in_range;
    r_ok       = ren & rd_ready & r_in_range;
    c_ok       = wr_commit & wr_ready;
    rl_ok      = rd_release & rd_ready;
    waddr_flat = MEM_AW'(wr_ptr_q) * MEM_AW'(BANK_DEPTH) + MEM_AW'(wadr);
    raddr_flat = MEM_AW'(rd_ptr_q) * MEM_AW'(BANK_DEPTH) + MEM_AW'(radr);
  end

  // Next-state for pointers, occupancy, read port and sticky error.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    rdata_d  = rdata_q;
    rvalid_d = r_ok;
    err_d    = err_q;

    if (c_ok) begin
      wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
    end
    if (rl_ok) begin
      rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
    end

    unique case ({c_ok, rl_ok})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    if (r_ok) begin
      rdata_d = mem[raddr_flat];
    end

    if ((wen & ~w_ok) | (ren & ~r_ok) |
        (wr_commit & ~wr_ready) | (rd_release & ~rd_ready)) begin
      err_d = 1'b1;
    end
  end

  // Control and read-data registers; reset discards all committed banks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  // Bank storage write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_ok) begin
      mem[waddr_flat] <= wdata;
    end
  end

endmodule

// File: tb/tb_multi_bank_buffer.sv
// Directed bench for multi_bank_buffer: reset, single-bank round trip,
// fill/drain with overflow, concurrent commit/release, empty and range
// violations, back-to-back streaming and asynchronous mid-run reset.
module tb_multi_bank_buffer;

  logic        clk;
  logic        rst_n;
  logic        wen;
  logic [8:0]  wadr;
  logic [63:0] wdata;
  logic        wr_commit;
  logic        wr_ready;
  logic        ren;
  logic [8:0]  radr;
  logic [63:0] rdata;
  logic        rvalid;
  logic        rd_release;
  logic        rd_ready;
  logic [1:0]  wr_bank;
  logic [1:0]  rd_bank;
  logic [2:0]  occupancy;
  logic        err;

  int checks = 0;
  int errors = 0;

  multi_bank_buffer #(
    .DATA_WIDTH      (64),
    .BANK_ADDR_WIDTH (9),
    .BANK_DEPTH      (200),
    .NUM_BANKS       (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wen        (wen),
    .wadr       (wadr),
    .wdata      (wdata),
    .wr_commit  (wr_commit),
    .wr_ready   (wr_ready),
    .ren        (ren),
    .radr       (radr),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .rd_release (rd_release),
    .rd_ready   (rd_ready),
    .wr_bank    (wr_bank),
    .rd_bank    (rd_bank),
    .occupancy  (occupancy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_inputs();
    wen = 1'b0; wadr = '0; wdata = '0; wr_commit = 1'b0;
    ren = 1'b0; radr = '0; rd_release = 1'b0;
  endtask

  // Advance one clock; inputs set before the call are sampled at this edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wen = 1'($urandom); wadr = 9'($urandom_range(0, 255)); wdata = {$urandom, $urandom};
      wr_commit = 1'($urandom); ren = 1'($urandom); radr = 9'($urandom_range(0, 255));
      rd_release = 1'($urandom);
      step();
    end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready); end
    checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL reset_rd_ready: got %b expected 0", rd_ready); end
    checks++; if (wr_bank !== 2'd0) begin errors++; $display("FAIL reset_wr_bank: got %0d expected 0", wr_bank); end
    checks++; if (rd_bank !== 2'd0) begin errors++; $display("FAIL reset_rd_bank: got %0d expected 0", rd_bank); end
    checks++; if (rdata !== 64'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", rvalid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    clear_inputs();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_bank();
    do_reset();
    wen = 1'b1; wadr = 9'd199; wdata = 64'hDEADBEEFDEADBEEF;
    step();
    wen = 1'b0; wr_commit = 1'b1;
    step();
    wr_commit = 1'b0;
    checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL single_occ: got %0d expected 1", occupancy); end
    checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL single_rd_ready: got %b expected 1", rd_ready); end
    checks++; if (wr_bank !== 2'd1) begin errors++; $display("FAIL single_wr_bank: got %0d expected 1", wr_bank); end
    ren = 1'b1; radr = 9'd199;
    step();
    ren = 1'b0;
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL single_rvalid: got %b expected 1", rvalid); end
    checks++; if (rdata !== 64'hDEADBEEFDEADBEEF) begin errors++; $display("FAIL single_rdata: got %h expected deadbeefdeadbeef", rdata); end
    step();
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL single_rvalid_drop: got %b expected 0", rvalid); end
    checks++; if (rdata !== 64'hDEADBEEFDEADBEEF) begin errors++; $display("FAIL single_rdata_hold: got %h expected deadbeefdeadbeef", rdata); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err: got %b expected 0", err); end
  endtask

  task automatic test_fill();
    do_reset();
    // Write and commit in the same cycle: data lands in the bank being handed over.
    for (int i = 0; i < 4; i++) begin
      wen = 1'b1; wadr = 9'd0; wdata = 64'(i + 1); wr_commit = 1'b1;
      step();
    end
    clear_inputs();
    checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL fill_occ: got %0d expected 4", occupancy); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL fill_wr_ready: got %b expected 0", wr_ready); end
    checks++; if (wr_bank !== 2'd0) begin errors++; $display("FAIL fill_wr_bank: got %0d expected 0", wr_bank); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL fill_err_before: got %b expected 0", err); end
    wen = 1'b1; wadr = 9'd0; wdata = 64'd5; wr_commit = 1'b1;
    step();
    clear_inputs();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL fill_overflow_err: got %b expected 1", err); end
    checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL fill_overflow_occ: got %0d expected 4", occupancy); end
    checks++; if (wr_bank !== 2'd0) begin errors++; $display("FAIL fill_overflow_wr_bank: got %0d expected 0", wr_bank); end
    for (int i = 0; i < 4; i++) begin
      ren = 1'b1; radr = 9'd0;
      // Last two banks: read and release in one cycle, which must still read the old bank.
      rd_release = (i >= 2);
      step();
      clear_inputs();
      checks++; if (rdata !== 64'(i + 1) || rvalid !== 1'b1) begin errors++; $display("FAIL fill_drain_rdata%0d: got %h/%b expected %h/1", i, rdata, rvalid, 64'(i + 1)); end
      if (i < 2) begin
        rd_release = 1'b1;
        step();
        clear_inputs();
      end
    end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL fill_drain_occ: got %0d expected 0", occupancy); end
    checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL fill_drain_rd_ready: got %b expected 0", rd_ready); end
    checks++; if (rd_bank !== 2'd0) begin errors++; $display("FAIL fill_drain_rd_bank: got %0d expected 0", rd_bank); end
  endtask

  task automatic test_concurrent();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wen = 1'b1; wadr = 9'd5; wdata = 64'(10 + i); wr_commit = 1'b1;
      step();
    end
    clear_inputs();
    rd_release = 1'b1;
    step();
    clear_inputs();
    checks++; if (occupancy !== 3'd2 || wr_bank !== 2'd3 || rd_bank !== 2'd1) begin errors++; $display("FAIL conc_setup: got occ=%0d wr=%0d rd=%0d expected occ=2 wr=3 rd=1", occupancy, wr_bank, rd_bank); end
    wen = 1'b1; wadr = 9'd5; wdata = 64'd13; wr_commit = 1'b1; rd_release = 1'b1;
    step();
    clear_inputs();
    checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL conc_occ: got %0d expected 2", occupancy); end
    checks++; if (wr_bank !== 2'd0) begin errors++; $display("FAIL conc_wr_wrap: got %0d expected 0", wr_bank); end
    checks++; if (rd_bank !== 2'd2) begin errors++; $display("FAIL conc_rd_bank: got %0d expected 2", rd_bank); end
    ren = 1'b1; radr = 9'd5;
    step();
    clear_inputs();
    checks++; if (rdata !== 64'd12) begin errors++; $display("FAIL conc_rdata_bank2: got %h expected c", rdata); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL conc_err: got %b expected 0", err); end
    wr_commit = 1'b1;
    step();
    step();
    clear_inputs();
    checks++; if (occupancy !== 3'd4 || wr_ready !== 1'b0) begin errors++; $display("FAIL conc_full: got occ=%0d wr_ready=%b expected 4/0", occupancy, wr_ready); end
    // Full: release is taken but the commit in the same cycle is refused.
    wr_commit = 1'b1; rd_release = 1'b1;
    step();
    clear_inputs();
    checks++; if (occupancy !== 3'd3 || wr_bank !== 2'd2 || rd_bank !== 2'd3) begin errors++; $display("FAIL conc_full_mix: got occ=%0d wr=%0d rd=%0d expected occ=3 wr=2 rd=3", occupancy, wr_bank, rd_bank); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL conc_full_err: got %b expected 1", err); end
    ren = 1'b1; radr = 9'd5;
    step();
    clear_inputs();
    checks++; if (rdata !== 64'd13) begin errors++; $display("FAIL conc_rdata_bank3: got %h expected d", rdata); end
  endtask

  task automatic test_empty_violations();
    do_reset();
    rd_release = 1'b1; ren = 1'b1; radr = 9'd0;
    step();
    clear_inputs();
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL empty_rvalid: got %b expected 0", rvalid); end
    checks++; if (rd_bank !== 2'd0) begin errors++; $display("FAIL empty_rd_bank: got %0d expected 0", rd_bank); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL empty_err: got %b expected 1", err); end
    step();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL empty_err_sticky: got %b expected 1", err); end
    // Empty: commit is taken but the release in the same cycle is refused.
    do_reset();
    wr_commit = 1'b1; rd_release = 1'b1;
    step();
    clear_inputs();
    checks++; if (occupancy !== 3'd1 || wr_bank !== 2'd1 || rd_bank !== 2'd0 || err !== 1'b1) begin errors++; $display("FAIL empty_mix: got occ=%0d wr=%0d rd=%0d err=%b expected 1/1/0/1", occupancy, wr_bank, rd_bank, err); end
    do_reset();
    wen = 1'b1; wadr = 9'd200; wdata = 64'd77;
    step();
    clear_inputs();
    checks++; if (err !== 1'b1 || occupancy !== 3'd0) begin errors++; $display("FAIL range_wadr: got err=%b occ=%0d expected 1/0", err, occupancy); end
    do_reset();
    wen = 1'b1; wadr = 9'd0; wdata = 64'h55; wr_commit = 1'b1;
    step();
    clear_inputs();
    ren = 1'b1; radr = 9'd200;
    step();
    clear_inputs();
    checks++; if (rvalid !== 1'b0 || err !== 1'b1 || rdata !== 64'd0) begin errors++; $display("FAIL range_radr: got rvalid=%b err=%b rdata=%h expected 0/1/0", rvalid, err, rdata); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      wen = 1'b1; wadr = 9'(i); wdata = 64'(100 + i);
      step();
    end
    clear_inputs();
    wr_commit = 1'b1;
    step();
    clear_inputs();
    for (int i = 0; i < 8; i++) begin
      wen = 1'b1; wadr = 9'(i); wdata = 64'(200 + i);
      ren = 1'b1; radr = 9'(7 - i);
      step();
      checks++; if (rvalid !== 1'b1 || rdata !== 64'(107 - i)) begin errors++; $display("FAIL b2b_read%0d: got %h/%b expected %h/1", i, rdata, rvalid, 64'(107 - i)); end
    end
    clear_inputs();
    wr_commit = 1'b1; rd_release = 1'b1;
    step();
    clear_inputs();
    checks++; if (occupancy !== 3'd1 || rd_bank !== 2'd1 || err !== 1'b0) begin errors++; $display("FAIL b2b_swap: got occ=%0d rd=%0d err=%b expected 1/1/0", occupancy, rd_bank, err); end
    ren = 1'b1; radr = 9'd3;
    step();
    clear_inputs();
    checks++; if (rdata !== 64'd203) begin errors++; $display("FAIL b2b_bank1: got %0d expected 203", rdata); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wen = 1'b1; wadr = 9'd0; wdata = 64'hA5; wr_commit = 1'b1;
    step();
    clear_inputs();
    wr_commit = 1'b1;
    step();
    step();
    clear_inputs();
    ren = 1'b1; radr = 9'd0; rd_release = 1'b1; wr_commit = 1'b1;
    step();
    clear_inputs();
    checks++; if (occupancy !== 3'd3 || rvalid !== 1'b1 || rdata !== 64'hA5) begin errors++; $display("FAIL mid_setup: got occ=%0d rvalid=%b rdata=%h expected 3/1/a5", occupancy, rvalid, rdata); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (occupancy !== 3'd0 || rd_ready !== 1'b0 || wr_ready !== 1'b1) begin errors++; $display("FAIL mid_flags: got occ=%0d rd_ready=%b wr_ready=%b expected 0/0/1", occupancy, rd_ready, wr_ready); end
    checks++; if (wr_bank !== 2'd0 || rd_bank !== 2'd0) begin errors++; $display("FAIL mid_ptrs: got wr=%0d rd=%0d expected 0/0", wr_bank, rd_bank); end
    checks++; if (rvalid !== 1'b0 || rdata !== 64'd0 || err !== 1'b0) begin errors++; $display("FAIL mid_data: got rvalid=%b rdata=%h err=%b expected 0/0/0", rvalid, rdata, err); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_single_bank();
    test_fill();
    test_concurrent();
    test_empty_violations();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
